pwm_fade_ctrl: RTL and testbench

Upstream programming stage for the 16-bit PWM block. Drives the PWM's d/sel write port to load period (top) and initial duty, resync its counter, then ramp duty (cmp) from a start value to an end value in fixed steps, one update every N PWM periods. Watches the PWM's cnt/top outputs to find period boundaries, so duty changes land on period edges. Used for LED fades and soft-start on motor PWM.

---
 rtl/pwm_fade_ctrl.sv | 151 +++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - programs a 16-bit PWM (top, cmp, cnt sync) then ramps cmp toward a target on period edges
module pwm_fade_ctrl #(
  parameter int W  = 16,
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [W-1:0]  top_cfg,
  input  logic [W-1:0]  from_duty,
  input  logic [W-1:0]  to_duty,
  input  logic [W-1:0]  step,
  input  logic [HW-1:0] hold,
  input  logic [W-1:0]  pwm_cnt,
  input  logic [W-1:0]  pwm_top,
  output logic [W-1:0]  d,
  output logic [1:0]    sel,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, LD_TOP, LD_CMP, SYNC, RUN, UPD, DONE} state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_CMP  = 2'b01;
  localparam logic [1:0] SEL_TOP  = 2'b10;
  localparam logic [1:0] SEL_CNT  = 2'b11;

  state_t        state, state_nx;
  logic [W-1:0]  to_r, step_r, cur, cur_nx, next_duty, d_nx;
  logic [HW-1:0] hold_r, hcnt, hcnt_nx;
  logic [1:0]    sel_nx;
  logic          busy_nx, done_nx, latch;
  logic          period_end;
  logic [W:0]    up_sum, dn_diff;

  assign period_end = (pwm_cnt >= pwm_top);

  // One extra bit catches carry/borrow so the ramp clamps at to_r instead of wrapping
  assign up_sum  = {1'b0, cur} + {1'b0, step_r};
  assign dn_diff = {1'b0, cur} - {1'b0, step_r};

  always_comb begin
    next_duty = cur;
    if (to_r > cur)
      next_duty = (up_sum >= {1'b0, to_r}) ? to_r : up_sum[W-1:0];
    else if (to_r < cur)
      next_duty = (dn_diff[W] || (dn_diff[W-1:0] <= to_r)) ? to_r : dn_diff[W-1:0];
  end

  always_comb begin
    state_nx = state;
    sel_nx   = SEL_NONE;
    d_nx     = d;
    busy_nx  = busy;
    done_nx  = 1'b0;
    cur_nx   = cur;
    hcnt_nx  = hcnt;
    latch    = 1'b0;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          latch    = 1'b1;
          cur_nx   = from_duty;
          state_nx = LD_TOP;
          sel_nx   = SEL_TOP;
          d_nx     = top_cfg;
          busy_nx  = 1'b1;
        end
      end
      LD_TOP: begin
        state_nx = LD_CMP;
        sel_nx   = SEL_CMP;
        d_nx     = cur;
      end
      LD_CMP: begin
        state_nx = SYNC;
        sel_nx   = SEL_CNT;
        d_nx     = '0;
      end
      SYNC: begin
        hcnt_nx = '0;
        if (cur == to_r) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (period_end) begin
          if (hcnt == hold_r - HW'(1)) begin
            state_nx = UPD;
            sel_nx   = SEL_CMP;
            d_nx     = next_duty;
            cur_nx   = next_duty;
            hcnt_nx  = '0;
          end else begin
            hcnt_nx = hcnt + HW'(1);
          end
        end
      end
      UPD: begin
        if (cur == to_r) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      d      <= '0;
      sel    <= SEL_NONE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cur    <= '0;
      hcnt   <= '0;
      to_r   <= '0;
      step_r <= '0;
      hold_r <= '0;
    end else begin
      state <= state_nx;
      d     <= d_nx;
      sel   <= sel_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      cur   <= cur_nx;
      hcnt  <= hcnt_nx;
      if (latch) begin
        to_r   <= to_duty;
        step_r <= (step == '0) ? W'(1) : step;
        hold_r <= (hold == '0) ? HW'(1) : hold;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - bench for pwm_fade_ctrl with a PWM model and write scoreboard
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] top_cfg = '0, from_duty = '0, to_duty = '0, step = '0;
  logic [7:0]  hold = '0;
  logic [15:0] pwm_cnt = '0, pwm_top = '0, pwm_cmp = '0;
  logic [15:0] d;
  logic [1:0]  sel;
  logic        busy, done;

  pwm_fade_ctrl #(.W(16), .HW(8)) dut (
    .clk(clk), .nrst(nrst), .start(start), .top_cfg(top_cfg), .from_duty(from_duty),
    .to_duty(to_duty), .step(step), .hold(hold), .pwm_cnt(pwm_cnt), .pwm_top(pwm_top),
    .d(d), .sel(sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Simple PWM: free-running counter wrapping after top, written through d/sel
  always @(posedge clk) begin
    if (sel == 2'b11) pwm_cnt <= d;
    else pwm_cnt <= (pwm_cnt >= pwm_top) ? 16'd0 : pwm_cnt + 16'd1;
    if (sel == 2'b10) pwm_top <= d;
    if (sel == 2'b01) pwm_cmp <= d;
  end

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] d;
    int          gap;
    bit          upd;
  } wr_t;

  typedef struct {
    logic [15:0] top, from, to, step;
    logic [7:0]  hold;
    int          exp_upd;
  } case_t;

  wr_t   exp_q[$];
  int    n_checks = 0, n_fail = 0;
  int    cyc = 0, last_wr = 0, upd_seen = 0, done_cnt = 0;
  case_t tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (done) done_cnt++;
      if (sel != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_sel", longint'(sel), 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_sel", longint'(sel), longint'(e.sel));
          check("write_d", longint'(d), longint'(e.d));
          if (e.gap != 0) check("write_gap", longint'(cyc - last_wr), longint'(e.gap));
          if (e.upd) upd_seen++;
        end
        last_wr = cyc;
      end
    end
  end

  task automatic push(logic [1:0] s, longint v, longint g, bit u);
    wr_t e;
    e.sel = s; e.d = 16'(v); e.gap = int'(g); e.upd = u;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; drives a one-cycle start and queues the expected write stream
  task automatic start_ramp(case_t c);
    longint cur, tgt, s, h, top, gap;
    top = c.top; cur = c.from; tgt = c.to;
    s = (c.step == 0) ? 1 : c.step;
    h = (c.hold == 0) ? 1 : c.hold;
    push(2'b10, top, 0, 0);
    push(2'b01, cur, 1, 0);
    push(2'b11, 0, 1, 0);
    gap = (top + 1) * (h - 1) + top + 2;
    while (cur != tgt) begin
      if (tgt > cur) cur = (cur + s > tgt) ? tgt : cur + s;
      else cur = (cur - s < tgt) ? tgt : cur - s;
      push(2'b01, cur, gap, 1);
      gap = (top + 1) * h;
    end
    upd_seen = 0;
    done_cnt = 0;
    top_cfg = c.top; from_duty = c.from; to_duty = c.to; step = c.step; hold = c.hold;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    top_cfg = 16'($urandom); from_duty = 16'($urandom); to_duty = 16'($urandom);
    step = 16'($urandom); hold = 8'($urandom);
  endtask

  task automatic wait_done(case_t c, string tag, bit interfere, bit start_at_done);
    bit seen = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (interfere && i == 12) begin
        top_cfg = 16'd3; from_duty = 16'd500; to_duty = 16'd0; step = 16'd7; hold = 8'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1;
        if (start_at_done) begin
          top_cfg = 16'd5; from_duty = 16'd1; to_duty = 16'd9; step = 16'd1; hold = 8'd1;
          start = 1'b1;
        end
        break;
      end
    end
    check({tag, "_done_seen"}, longint'(seen), 1);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulses"}, longint'(done_cnt), 1);
    check({tag, "_busy_after"}, longint'(busy), 0);
    check({tag, "_done_after"}, longint'(done), 0);
    check({tag, "_sel_after"}, longint'(sel), 0);
    check({tag, "_queue_left"}, longint'(exp_q.size()), 0);
    check({tag, "_upd_count"}, longint'(upd_seen), longint'(c.exp_upd));
    check({tag, "_final_cmp"}, longint'(pwm_cmp), longint'(c.to));
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{16'd9,     16'd0,     16'd10,    16'd4,     8'd1, 3};
    tbl[1] = '{16'd4,     16'd100,   16'd90,    16'd3,     8'd2, 4};
    tbl[2] = '{16'd3,     16'hFFF0,  16'hFFFF,  16'h0100,  8'd1, 1};
    tbl[3] = '{16'd3,     16'h0010,  16'h0000,  16'h0100,  8'd1, 1};
    tbl[4] = '{16'd5,     16'd50,    16'd50,    16'd1,     8'd1, 0};
    tbl[5] = '{16'd2,     16'd0,     16'd2,     16'd0,     8'd0, 2};
    tbl[6] = '{16'd6,     16'd20,    16'd5,     16'd5,     8'd3, 3};

    repeat (3) @(negedge clk);
    check("reset_sel", longint'(sel), 0);
    check("reset_d", longint'(d), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_ramp(tbl[i]);
      check($sformatf("case%0d_busy", i), longint'(busy), 1);
      wait_done(tbl[i], $sformatf("case%0d", i), 0, 0);
    end

    start_ramp(tbl[0]);
    wait_done(tbl[0], "interfere", 1, 0);

    start_ramp(tbl[5]);
    wait_done(tbl[5], "start_at_done", 0, 1);
    start_ramp(tbl[4]);
    wait_done(tbl[4], "after_done_start", 0, 0);

    start_ramp(tbl[1]);
    repeat (20) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("midrun_reset_sel", longint'(sel), 0);
    check("midrun_reset_d", longint'(d), 0);
    check("midrun_reset_busy", longint'(busy), 0);
    check("midrun_reset_done", longint'(done), 0);
    exp_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    start_ramp(tbl[0]);
    wait_done(tbl[0], "post_reset", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
